// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master
// Purpose  : Processor-side initiator for the 8-bit port I/O bus. Runs single
//            IN/OUT transactions and, for blocking UART commands, polls the
//            UART status port until the access can go ahead or the poll limit
//            is used up.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_master #(
    parameter int RD_LATENCY = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_blocking,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic [7:0] IO_port_ID,
    output logic [7:0] IO_write_data,
    output logic       IO_write_strobe,
    output logic       IO_read_strobe,
    input  logic [7:0] IO_read_data
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_poll_stb  = 3'd1;
    localparam logic [2:0] c_st_poll_wait = 3'd2;
    localparam logic [2:0] c_st_acc_stb   = 3'd3;
    localparam logic [2:0] c_st_rd_wait   = 3'd4;

    // UART data port and its two status ports
    localparam logic [7:0] c_uart_data    = 8'h01;
    localparam logic [7:0] c_uart_rx_stat = 8'h02;
    localparam logic [7:0] c_uart_tx_stat = 8'h03;

    // Wait counter counts down to zero on the capture edge
    localparam logic [3:0] c_wait_init  = 4'(RD_LATENCY - 1);
    localparam logic [7:0] c_poll_limit = 8'(POLL_LIMIT);

    logic [2:0] r_state;
    logic       r_write;
    logic [7:0] r_port;
    logic [7:0] r_wdata;
    logic [7:0] r_poll_cnt;
    logic [3:0] r_wait;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_rsp_timeout;
    logic [7:0] r_io_port;
    logic [7:0] r_io_wdata;
    logic       r_wr_stb;
    logic       r_rd_stb;

    logic       w_poll_pass;
    logic [7:0] w_poll_cnt_next;

    // TX status passes when "full" bit is clear, RX status when "data present" is set
    assign w_poll_pass     = r_write ? ~IO_read_data[0] : IO_read_data[0];
    assign w_poll_cnt_next = r_poll_cnt + 8'd1;

    assign cmd_ready       = (r_state == c_st_idle);
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;
    assign rsp_timeout     = r_rsp_timeout;
    assign IO_port_ID      = r_io_port;
    assign IO_write_data   = r_io_wdata;
    assign IO_write_strobe = r_wr_stb;
    assign IO_read_strobe  = r_rd_stb;

    // Transaction sequencer with registered bus and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_write       <= 1'b0;
            r_port        <= 8'h00;
            r_wdata       <= 8'h00;
            r_poll_cnt    <= 8'h00;
            r_wait        <= 4'h0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 8'h00;
            r_rsp_timeout <= 1'b0;
            r_io_port     <= 8'h00;
            r_io_wdata    <= 8'h00;
            r_wr_stb      <= 1'b0;
            r_rd_stb      <= 1'b0;
        end else begin
            // Strobes and the response pulse last exactly one cycle
            r_rsp_valid <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_rd_stb    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_write    <= cmd_write;
                        r_port     <= cmd_port;
                        r_wdata    <= cmd_wdata;
                        r_poll_cnt <= 8'h00;
                        if (cmd_blocking && (cmd_port == c_uart_data)) begin
                            r_state   <= c_st_poll_stb;
                            r_rd_stb  <= 1'b1;
                            r_io_port <= cmd_write ? c_uart_tx_stat : c_uart_rx_stat;
                        end else begin
                            r_state   <= c_st_acc_stb;
                            r_io_port <= cmd_port;
                            if (cmd_write) begin
                                r_wr_stb   <= 1'b1;
                                r_io_wdata <= cmd_wdata;
                            end else begin
                                r_rd_stb   <= 1'b1;
                            end
                        end
                    end
                end
                c_st_poll_stb: begin
                    r_state <= c_st_poll_wait;
                    r_wait  <= c_wait_init;
                end
                c_st_poll_wait: begin
                    if (r_wait != 4'h0) begin
                        r_wait <= r_wait - 4'h1;
                    end else if (w_poll_pass) begin
                        r_state   <= c_st_acc_stb;
                        r_io_port <= r_port;
                        if (r_write) begin
                            r_wr_stb   <= 1'b1;
                            r_io_wdata <= r_wdata;
                        end else begin
                            r_rd_stb   <= 1'b1;
                        end
                    end else begin
                        r_poll_cnt <= w_poll_cnt_next;
                        if (w_poll_cnt_next == c_poll_limit) begin
                            // Give up without touching the data port
                            r_state       <= c_st_idle;
                            r_io_port     <= 8'h00;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_data    <= 8'h00;
                            r_rsp_timeout <= 1'b1;
                        end else begin
                            r_state  <= c_st_poll_stb;
                            r_rd_stb <= 1'b1;
                        end
                    end
                end
                c_st_acc_stb: begin
                    if (r_write) begin
                        r_state       <= c_st_idle;
                        r_io_port     <= 8'h00;
                        r_io_wdata    <= 8'h00;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= 8'h00;
                        r_rsp_timeout <= 1'b0;
                    end else begin
                        r_state <= c_st_rd_wait;
                        r_wait  <= c_wait_init;
                    end
                end
                c_st_rd_wait: begin
                    if (r_wait != 4'h0) begin
                        r_wait <= r_wait - 4'h1;
                    end else begin
                        r_state       <= c_st_idle;
                        r_io_port     <= 8'h00;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= IO_read_data;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
